// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler in front of a single uart_tx, with launch timeout
// and serialised speed reconfiguration followed by a guard settle period.
module uart_tx_scheduler #(
    parameter int          NUM_REQ   = 4,
    parameter int          START_TO  = 64,
    parameter int          GUARD_CYC = 16,
    parameter logic [1:0]  RST_SPEED = 2'b00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [2:0]             tx_owner,
    input  logic                   cfg_valid,
    input  logic [1:0]             cfg_speed,
    output logic                   cfg_ready,
    output logic [1:0]             speed,
    output logic                   pulse,
    output logic                   idle,
    output logic                   err
);

    localparam int CNT_MAX = (START_TO > GUARD_CYC) ? START_TO : GUARD_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RECONF, S_SETTLE
    } state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [1:0]           r_speed, r_cfg_speed;
    logic [7:0]           r_tx_data;
    logic [2:0]           r_owner, r_last_grant;
    logic                 w_found_hi, w_found_lo, w_any, w_grant_en;
    logic [2:0]           w_hi, w_lo, w_grant;
    logic [7:0]           w_byte;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic                 w_tx_start, w_cfg_ready, w_pulse, w_err;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(r_last_grant)) begin
                    w_found_hi = 1'b1;
                    w_hi       = 3'(i);
                end else begin
                    w_found_lo = 1'b1;
                    w_lo       = 3'(i);
                end
            end
        end
        w_any   = w_found_hi | w_found_lo;
        w_grant = w_found_hi ? w_hi : w_lo;
        w_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == w_grant) w_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_req_ready = '0;
        w_cfg_ready = 1'b0;
        w_tx_start  = 1'b0;
        w_pulse     = 1'b0;
        w_err       = 1'b0;
        w_grant_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_cfg_ready = 1'b1;
                    w_next      = S_RECONF;
                end else if (w_any) begin
                    w_req_ready = NUM_REQ'(1) << w_grant;
                    w_grant_en  = 1'b1;
                    w_next      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_tx_start = 1'b1;
                w_cnt_next = CW'(START_TO - 1);
                w_next     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_cnt == '0) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) w_next = S_IDLE;
            end
            S_RECONF: begin
                w_pulse    = 1'b1;
                w_cnt_next = CW'(GUARD_CYC - 1);
                w_next     = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == '0) w_next = S_IDLE;
                else             w_cnt_next = r_cnt - CW'(1);
            end
            default: w_next = S_IDLE;
        endcase
        // Strobes stay quiet while reset is held so nothing is accepted and then discarded.
        if (rst) begin
            w_req_ready = '0;
            w_cfg_ready = 1'b0;
            w_tx_start  = 1'b0;
            w_pulse     = 1'b0;
            w_err       = 1'b0;
            w_grant_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_speed      <= RST_SPEED;
            r_cfg_speed  <= RST_SPEED;
            r_tx_data    <= '0;
            r_owner      <= '0;
            r_last_grant <= 3'(NUM_REQ - 1);
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_cfg_ready) r_cfg_speed <= cfg_speed;
            if (w_grant_en) begin
                r_tx_data    <= w_byte;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == S_RECONF) r_speed <= r_cfg_speed;
        end
    end

    assign req_ready = w_req_ready;
    assign cfg_ready = w_cfg_ready;
    assign tx_start  = w_tx_start;
    assign pulse     = w_pulse;
    assign err       = w_err;
    assign tx_data   = r_tx_data;
    assign tx_owner  = r_owner;
    assign speed     = r_speed;
    assign idle      = (r_state == S_IDLE);

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing the single uart_tx (2..8).
REQ-002 Parameter START_TO, default 64, clk cycles allowed between tx_start and tx_busy rising.
REQ-003 Parameter GUARD_CYC, default 16, idle settle cycles after a speed change (>=1).
REQ-004 Parameter RST_SPEED, default 2'b00, speed code after reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_valid  input  NUM_REQ  per-requester byte-pending flag.
REQ-008 req_data  input  NUM_REQ*8  packed bytes; requester i at bits [8i+7:8i].
REQ-009 req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-010 tx_busy  input  1  high while uart_tx serialises a frame (already synchronous to clk).
REQ-011 tx_start  output  1  one-cycle launch strobe to uart_tx.
REQ-012 tx_data  output  8  byte presented to uart_tx, stable from accept until next accept.
REQ-013 tx_owner  output  3  index of requester owning the current or last frame.
REQ-014 cfg_valid  input  1  speed-change request; cfg_speed  input  2  requested speed code.
REQ-015 cfg_ready  output  1  one-cycle accept pulse for cfg_valid.
REQ-016 speed  output  2  speed code driven to clk_divider, uart_rx and uart_tx.
REQ-017 pulse  output  1  one-cycle strobe: speed has just changed.
REQ-018 idle  output  1  high exactly when the state machine is in IDLE.
REQ-019 err  output  1  one-cycle pulse on start timeout.

Function
REQ-020 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RECONF, SETTLE.
REQ-021 IDLE with cfg_valid=1: cfg_ready=1 that cycle, latch cfg_speed, next RECONF; config takes priority over any req_valid in the same cycle.
REQ-022 IDLE with cfg_valid=0 and any req_valid: grant first set bit searching last_grant+1, last_grant+2, ... modulo NUM_REQ; req_ready[grant]=1 that cycle; tx_data<=byte, tx_owner<=grant, last_grant<=grant; next LAUNCH.
REQ-023 IDLE with nothing pending: remain in IDLE; all strobes 0.
REQ-024 LAUNCH: tx_start=1 for exactly this cycle; load timeout counter with START_TO-1; next WAIT_BUSY.
REQ-025 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; else counter=0 -> err=1 one cycle, next IDLE (byte dropped, no retry); else decrement.
REQ-026 WAIT_DONE: stay while tx_busy=1; tx_busy=0 -> IDLE. Earliest next grant is the cycle after returning to IDLE.
REQ-027 RECONF: speed<=latched code, pulse=1 this cycle; load settle counter with GUARD_CYC-1; next SETTLE.
REQ-028 SETTLE: decrement; on 0 -> IDLE. No grants or cfg accepts in RECONF/SETTLE.
REQ-029 speed never changes outside RECONF, hence never while a frame is in flight.
REQ-030 cfg request equal to current speed is still accepted and still produces pulse and full settle.
REQ-031 req_valid dropped before its req_ready is legal; requester is simply not considered. req_data sampled only in the grant cycle.
REQ-032 At most one of req_ready, cfg_ready is high in any cycle; tx_start at most once per grant.
REQ-033 Latency: req_valid seen in IDLE -> req_ready same cycle -> tx_start next cycle.

Reset
REQ-034 rst=1 at a clock edge forces IDLE from any state, aborting wait/settle counts without err or pulse.
REQ-035 Reset values: speed=RST_SPEED, tx_data=0, tx_owner=0, tx_start=0, req_ready=0, cfg_ready=0, pulse=0, err=0, counters=0, last_grant=NUM_REQ-1 (requester 0 wins first); idle=1 the cycle after reset.

Verification
REQ-036 After reset, req_valid=4'b1111, tx_busy modelled 10 cycles per frame -> grant order 0,1,2,3,0; tx_start 1 cycle after each req_ready.
REQ-037 Same cycle cfg_valid=1 (cfg_speed=2'b11) and req_valid=4'b0010 -> cfg_ready first, speed=3 with pulse, 16 idle cycles, then req_ready=4'b0010.
REQ-038 cfg_valid during WAIT_DONE -> cfg_ready held 0 until frame ends, speed unchanged throughout tx_busy=1.
REQ-039 tx_busy never rises after tx_start -> err pulse exactly 64 cycles after LAUNCH, idle=1 next cycle, next requester granted.
REQ-040 rst asserted mid-WAIT_DONE and mid-SETTLE -> all outputs at reset values next cycle, speed=RST_SPEED, no pulse/err.
